// File: rtl/enc_pkg.sv
// Shared definitions for the request arbiter feeding the 8-to-3 encoder stage.
package enc_pkg;

  localparam int unsigned DEFAULT_N = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set bit of vec at or above ptr, wrapping to bit 0.
module rr_pick #(
  parameter int unsigned N    = 8,
  parameter int unsigned IDXW = $clog2(N)
) (
  input  logic [N-1:0]    vec,
  input  logic [IDXW-1:0] ptr,
  output logic [N-1:0]    onehot,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  logic [N-1:0]   mask;
  logic [2*N-1:0] dbl;

  // Lower copy keeps only bits at/above ptr; upper copy supplies the wrapped-around candidates.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      mask[i] = (i >= int'(ptr));
    end
    dbl = {vec, vec & mask};
  end

  always_comb begin
    logic hit;
    hit    = 1'b0;
    onehot = '0;
    idx    = '0;
    for (int i = 0; i < 2 * N; i++) begin
      if (!hit && dbl[i]) begin
        hit = 1'b1;
        if (i >= N) begin
          idx            = IDXW'(i - N);
          onehot[i - N]  = 1'b1;
        end else begin
          idx            = IDXW'(i);
          onehot[i]      = 1'b1;
        end
      end
    end
    any = hit;
  end

endmodule

// File: rtl/req_onehot_arbiter.sv
// Captures request rising edges into a pending register and offers one round-robin winner
// at a time as a one-hot vector plus index over valid/ready.
module req_onehot_arbiter
  import enc_pkg::*;
#(
  parameter int unsigned N    = DEFAULT_N,
  parameter int unsigned IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N-1:0]    req_in,
  output logic [N-1:0]    gnt_onehot,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  input  logic            gnt_ready,
  output logic [N-1:0]    pending,
  output logic [N-1:0]    dropped,
  input  logic            clr_drop
);

  state_e          state_q, state_d;
  logic [N-1:0]    req_q;
  logic [N-1:0]    rise;
  logic [N-1:0]    clr;
  logic [N-1:0]    drop_set;
  logic [N-1:0]    pending_d, dropped_d;
  logic [N-1:0]    onehot_d;
  logic [IDXW-1:0] idx_d;
  logic            valid_d;
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
  logic            accept;

  logic [N-1:0]    pick_onehot;
  logic [IDXW-1:0] pick_idx;
  logic            pick_any;

  rr_pick #(
    .N    (N),
    .IDXW (IDXW)
  ) u_rr_pick (
    .vec    (pending),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign accept = gnt_valid & gnt_ready;
  assign rise   = req_in & ~req_q;
  assign clr    = accept ? gnt_onehot : '0;

  // A fresh edge re-arms a bit even in the cycle its previous request is granted.
  assign drop_set  = rise & pending & ~clr;
  assign pending_d = (pending & ~clr) | rise;
  assign dropped_d = (clr_drop ? '0 : dropped) | drop_set;

  always_comb begin
    state_d  = state_q;
    onehot_d = gnt_onehot;
    idx_d    = gnt_idx;
    valid_d  = gnt_valid;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (en && pick_any) begin
          state_d  = ST_OFFER;
          onehot_d = pick_onehot;
          idx_d    = pick_idx;
          valid_d  = 1'b1;
        end
      end
      ST_OFFER: begin
        if (accept) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (gnt_idx == IDXW'(N - 1)) ? '0 : gnt_idx + IDXW'(1);
          onehot_d = '0;
          idx_d    = '0;
          valid_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      pending    <= '0;
      dropped    <= '0;
      gnt_onehot <= '0;
      gnt_idx    <= '0;
      gnt_valid  <= 1'b0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_in;
      pending    <= pending_d;
      dropped    <= dropped_d;
      gnt_onehot <= onehot_d;
      gnt_idx    <= idx_d;
      gnt_valid  <= valid_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_req_onehot_arbiter.sv
// Scoreboard bench: a behavioural model predicts each offer; a monitor checks DUT offers.
module tb_req_onehot_arbiter;

  localparam int N    = 8;
  localparam int IDXW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [N-1:0]    req_in;
  logic [N-1:0]    gnt_onehot;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_valid;
  logic            gnt_ready;
  logic [N-1:0]    pending;
  logic [N-1:0]    dropped;
  logic            clr_drop;

  always #5 clk = ~clk;

  req_onehot_arbiter #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req_in     (req_in),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .gnt_valid  (gnt_valid),
    .gnt_ready  (gnt_ready),
    .pending    (pending),
    .dropped    (dropped),
    .clr_drop   (clr_drop)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain bit arrays, a modular scan pointer and an offer flag.
  bit m_req_q[N];
  bit m_pend[N];
  bit m_drop[N];
  bit m_offer;
  int m_idx;
  int m_ptr;
  int exp_q[$];

  function automatic logic [N-1:0] pack(input bit a[N]);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = a[i];
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_req_q[i] = 1'b0;
        m_pend[i]  = 1'b0;
        m_drop[i]  = 1'b0;
      end
      m_offer = 1'b0;
      m_idx   = 0;
      m_ptr   = 0;
      exp_q.delete();
    end else begin
      bit acc;
      bit found;
      bit np[N];
      acc = m_offer && gnt_ready;
      for (int i = 0; i < N; i++) begin
        bit r, c;
        r = req_in[i] && !m_req_q[i];
        c = acc && (i == m_idx);
        if (clr_drop) m_drop[i] = 1'b0;
        if (r && m_pend[i] && !c) m_drop[i] = 1'b1;
        np[i] = (m_pend[i] && !c) || r;
      end
      if (!m_offer) begin
        found = 1'b0;
        if (en) begin
          for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (!found && m_pend[j]) begin
              found   = 1'b1;
              m_idx   = j;
              m_offer = 1'b1;
              exp_q.push_back(j);
            end
          end
        end
      end else if (acc) begin
        m_ptr   = (m_idx + 1) % N;
        m_offer = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        m_pend[i]  = np[i];
        m_req_q[i] = req_in[i];
      end
    end
  end

  // Monitor: samples 1 time unit after each rising edge.
  bit              prev_v = 1'b0;
  logic [IDXW-1:0] held_idx;
  logic [N-1:0]    held_oh;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      check("gnt_valid", 32'(gnt_valid), 32'(m_offer));
      check("pending", 32'(pending), 32'(pack(m_pend)));
      check("dropped", 32'(dropped), 32'(pack(m_drop)));
      if (gnt_valid) begin
        if (!prev_v) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got offer idx %0d expected none", gnt_idx);
          end else begin
            int e;
            e = exp_q.pop_front();
            check("gnt_idx", 32'(gnt_idx), 32'(e));
            check("gnt_onehot", 32'(gnt_onehot), 32'(1) << e);
          end
        end else begin
          check("hold_idx", 32'(gnt_idx), 32'(held_idx));
          check("hold_onehot", 32'(gnt_onehot), 32'(held_oh));
        end
        held_idx = gnt_idx;
        held_oh  = gnt_onehot;
      end else begin
        check("idle_onehot", 32'(gnt_onehot), 32'(0));
        check("idle_idx", 32'(gnt_idx), 32'(0));
      end
      prev_v = gnt_valid;
    end
  end

  task automatic drive(input logic [N-1:0] r, input logic e, input logic rdy, input logic cd);
    @(negedge clk);
    req_in    = r;
    en        = e;
    gnt_ready = rdy;
    clr_drop  = cd;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req_in = '0; gnt_ready = 1'b0; clr_drop = 1'b0;
    idle(3);
    rst = 1'b0;

    // Reset mid-offer: outputs clear without waiting for an edge.
    drive(8'h04, 1'b1, 1'b0, 1'b0);
    idle(4);
    #2 rst = 1'b1;
    #1;
    check("rst_valid", 32'(gnt_valid), 32'(0));
    check("rst_onehot", 32'(gnt_onehot), 32'(0));
    check("rst_idx", 32'(gnt_idx), 32'(0));
    check("rst_pending", 32'(pending), 32'(0));
    check("rst_dropped", 32'(dropped), 32'(0));
    @(negedge clk);
    rst = 1'b0; req_in = '0; gnt_ready = 1'b0;

    // Single request with ready high.
    drive(8'h10, 1'b1, 1'b1, 1'b0);
    idle(5);
    drive(8'h00, 1'b1, 1'b1, 1'b0);
    idle(2);

    // Round robin and wrap, starting from a fresh pointer.
    rst = 1'b1; idle(1); rst = 1'b0;
    drive(8'h81, 1'b0, 1'b1, 1'b0);
    idle(2);
    drive(8'h80, 1'b1, 1'b1, 1'b0);
    idle(3);
    drive(8'h81, 1'b1, 1'b1, 1'b0);
    idle(6);

    // Backpressure with a new edge arriving during the offer.
    drive(8'h00, 1'b1, 1'b0, 1'b0);
    drive(8'h02, 1'b1, 1'b0, 1'b0);
    idle(3);
    drive(8'h22, 1'b1, 1'b0, 1'b0);
    idle(5);
    drive(8'h22, 1'b1, 1'b1, 1'b0);
    idle(6);

    // Collision: edge on the granted bit in its accept cycle, then a true drop on bit 3.
    drive(8'h00, 1'b1, 1'b0, 1'b0);
    drive(8'h04, 1'b1, 1'b0, 1'b0);
    drive(8'h00, 1'b1, 1'b0, 1'b0);
    idle(3);
    drive(8'h04, 1'b1, 1'b1, 1'b0);
    drive(8'h04, 1'b0, 1'b0, 1'b0);
    drive(8'h08, 1'b0, 1'b0, 1'b0);
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    drive(8'h08, 1'b0, 1'b0, 1'b0);
    idle(3);
    drive(8'h08, 1'b0, 1'b0, 1'b1);
    drive(8'h08, 1'b0, 1'b0, 1'b0);

    // Enable low with everything pending, then en dropped mid-offer.
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    drive(8'hFF, 1'b0, 1'b0, 1'b0);
    idle(6);
    drive(8'hFF, 1'b1, 1'b0, 1'b0);
    drive(8'hFF, 1'b0, 1'b0, 1'b0);
    idle(4);
    drive(8'hFF, 1'b0, 1'b1, 1'b0);
    idle(6);
    drive(8'hFF, 1'b1, 1'b1, 1'b0);
    idle(30);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      drive(N'($urandom & $urandom), ($urandom % 8) != 0, ($urandom % 3) != 0,
            ($urandom % 16) == 0);
    end

    drive('0, 1'b0, 1'b1, 1'b0);
    idle(10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
